// File: rtl/up_counter_seq_ctrl_if.sv
// Sequencer <-> environment bundle: run control, counter hookup and status.
// The master side drives start/stop/mode/limit and returns the counter's q.
interface up_counter_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int WCNT_W = 8
);
    logic              start;
    logic              stop;
    logic              mode;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  q;
    logic              cnt_clr;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic              wrap;
    logic [WCNT_W-1:0] wrap_cnt;

    modport master (
        output start, stop, mode, limit, q,
        input  cnt_clr, cnt_en, busy, done, wrap, wrap_cnt
    );

    modport slave (
        input  start, stop, mode, limit, q,
        output cnt_clr, cnt_en, busy, done, wrap, wrap_cnt
    );
endinterface

// File: rtl/up_counter_seq_ctrl.sv
// Sequencing controller for an external up counter: one-shot or
// continuous modulo-(limit+1) runs with pause/resume/abort and wrap tally.
module up_counter_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int WCNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    up_counter_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            st;
    state_t            nxt;
    logic [WIDTH-1:0]  limit_r;
    logic              mode_r;
    logic [WCNT_W-1:0] wcnt;
    logic              load;
    logic              clr_c;
    logic              en_c;
    logic              wrap_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= S_IDLE;
        else      st <= nxt;
    end

    // Run parameters latched at start; wrap tally saturates at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limit_r <= '0;
            mode_r  <= 1'b0;
            wcnt    <= '0;
        end else if (load) begin
            limit_r <= bus.limit;
            mode_r  <= bus.mode;
            wcnt    <= '0;
        end else if (wrap_c && (wcnt != '1)) begin
            wcnt <= wcnt + WCNT_W'(1);
        end
    end

    // Next state and counter controls; stop always beats start
    always_comb begin
        nxt    = st;
        load   = 1'b0;
        clr_c  = 1'b0;
        en_c   = 1'b0;
        wrap_c = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    load = 1'b1;
                    nxt  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_c = 1'b1;
                nxt   = S_RUN;
            end
            S_RUN: begin
                if (bus.stop) begin
                    nxt = S_HOLD;
                end else if (bus.q != limit_r) begin
                    en_c = 1'b1;
                end else if (!mode_r) begin
                    nxt = S_DONE;
                end else begin
                    clr_c  = 1'b1;
                    wrap_c = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.stop)       nxt = S_IDLE;
                else if (bus.start) nxt = S_RUN;
            end
            S_DONE: begin
                nxt = S_IDLE;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cnt_clr  = clr_c;
    assign bus.cnt_en   = en_c;
    assign bus.wrap     = wrap_c;
    assign bus.wrap_cnt = wcnt;
    assign bus.busy     = (st != S_IDLE);
    assign bus.done     = (st == S_DONE);

endmodule

// File: tb/tb_up_counter_seq_ctrl.sv
// Directed bench for up_counter_seq_ctrl with a behavioural counter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_up_counter_seq_ctrl;

    localparam int W = 4;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] qm  = '0;
    int           tests = 0;
    int           fails = 0;
    int           done_seen = 0;

    up_counter_seq_ctrl_if #(.WIDTH(W), .WCNT_W(C)) bus ();

    up_counter_seq_ctrl #(.WIDTH(W), .WCNT_W(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Counter model: clear wins over enable, natural rollover
    always_ff @(posedge clk) begin
        if (bus.cnt_clr)     qm <= '0;
        else if (bus.cnt_en) qm <= qm + 4'd1;
    end

    assign bus.q = qm;

    always @(negedge clk) if (bus.done) done_seen++;

    // Start pulse across one rising edge; returns in the CLEAR cycle
    task automatic kick(input logic [W-1:0] lim, input logic md);
        bus.limit = lim;
        bus.mode  = md;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.limit = '0;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap} !== 5'b0
            || bus.wrap_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_state got %b/%0d exp 0/0",
                {bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap},
                bus.wrap_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        kick(4'd1, 1'b1);
        repeat (7) @(negedge clk);
        tests++;
        if (bus.wrap_cnt !== 8'd3 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_run got wc=%0d busy=%b exp wc=3 busy=1",
                bus.wrap_cnt, bus.busy);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap} !== 5'b0
            || bus.wrap_cnt !== 8'd0) begin
            fails++;
            $display("FAIL async_reset got %b/%0d exp 0/0",
                {bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.wrap},
                bus.wrap_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        kick(4'd2, 1'b0);
        tests++;
        if (bus.cnt_clr !== 1'b1 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_clear got clr=%b busy=%b exp 1 1",
                bus.cnt_clr, bus.busy);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.q !== 4'd2) begin
            fails++;
            $display("FAIL post_reset_done got done=%b q=%0d exp 1 2",
                bus.done, bus.q);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_oneshot();
        logic [W-1:0] eq;
        int           nd;
        nd = 0;
        kick(4'd5, 1'b0);
        tests++;
        if (bus.cnt_clr !== 1'b1) begin
            fails++;
            $display("FAIL os_clear got %b exp 1", bus.cnt_clr);
        end
        for (int n = 2; n <= 12; n++) begin
            @(negedge clk);
            eq = (n >= 7) ? 4'd5 : 4'(n - 2);
            if (bus.done === 1'b1) nd++;
            tests++;
            if (bus.q !== eq) begin
                fails++;
                $display("FAIL os_q n=%0d got %0d exp %0d", n, bus.q, eq);
            end
            tests++;
            if (bus.done !== (n == 8)) begin
                fails++;
                $display("FAIL os_done n=%0d got %b exp %b",
                    n, bus.done, (n == 8));
            end
            tests++;
            if (bus.busy !== (n <= 8)) begin
                fails++;
                $display("FAIL os_busy n=%0d got %b exp %b",
                    n, bus.busy, (n <= 8));
            end
        end
        tests++;
        if (nd != 1) begin
            fails++;
            $display("FAIL os_done_count got %0d exp 1", nd);
        end
    endtask

    task automatic test_continuous();
        kick(4'd3, 1'b1);
        for (int n = 2; n <= 17; n++) begin
            @(negedge clk);
            tests++;
            if (bus.q !== 4'((n - 2) % 4)
                || bus.wrap !== ((n - 2) % 4 == 3)) begin
                fails++;
                $display("FAIL cont n=%0d got q=%0d wrap=%b exp q=%0d wrap=%b",
                    n, bus.q, bus.wrap, (n - 2) % 4, ((n - 2) % 4 == 3));
            end
        end
        tests++;
        if (bus.wrap_cnt !== 8'd3) begin
            fails++;
            $display("FAIL cont_tally got %0d exp 3", bus.wrap_cnt);
        end
        repeat (1200) @(negedge clk);
        tests++;
        if (bus.wrap_cnt !== 8'd255 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL cont_sat got %0d busy=%b exp 255 1",
                bus.wrap_cnt, bus.busy);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.cnt_en !== 1'b0) begin
            fails++;
            $display("FAIL cont_hold got busy=%b en=%b exp 1 0",
                bus.busy, bus.cnt_en);
        end
        @(negedge clk);
        bus.stop = 1'b0;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL cont_abort got busy=%b exp 0", bus.busy);
        end
    endtask

    task automatic test_pause();
        done_seen = 0;
        kick(4'd6, 1'b0);
        @(negedge clk);
        tests++;
        if (bus.wrap_cnt !== 8'd0) begin
            fails++;
            $display("FAIL pause_tally_clr got %0d exp 0", bus.wrap_cnt);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (bus.q !== 4'd2) begin
            fails++;
            $display("FAIL pause_pre got q=%0d exp 2", bus.q);
        end
        bus.stop = 1'b1;
        #1;
        tests++;
        if (bus.cnt_en !== 1'b0) begin
            fails++;
            $display("FAIL pause_stop_en got %b exp 0", bus.cnt_en);
        end
        @(negedge clk);
        bus.stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (bus.q !== 4'd2 || bus.cnt_en !== 1'b0 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL pause_hold i=%0d got q=%0d en=%b busy=%b",
                    i, bus.q, bus.cnt_en, bus.busy);
            end
            @(negedge clk);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.q !== 4'd2 || bus.cnt_en !== 1'b1) begin
            fails++;
            $display("FAIL resume_run got q=%0d en=%b exp 2 1",
                bus.q, bus.cnt_en);
        end
        @(negedge clk);
        tests++;
        if (bus.q !== 4'd3) begin
            fails++;
            $display("FAIL resume_q got %0d exp 3", bus.q);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.cnt_en !== 1'b0) begin
            fails++;
            $display("FAIL pause2_hold got busy=%b en=%b exp 1 0",
                bus.busy, bus.cnt_en);
        end
        @(negedge clk);
        bus.stop = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.q !== 4'd3) begin
            fails++;
            $display("FAIL abort got busy=%b q=%0d exp 0 3", bus.busy, bus.q);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d pulses exp 0", done_seen);
        end
    endtask

    task automatic test_corners();
        kick(4'd0, 1'b0);
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.cnt_en !== 1'b0) begin
            fails++;
            $display("FAIL lim0_run got done=%b en=%b exp 0 0",
                bus.done, bus.cnt_en);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.q !== 4'd0) begin
            fails++;
            $display("FAIL lim0_done got done=%b q=%0d exp 1 0",
                bus.done, bus.q);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL lim0_idle got busy=%b exp 0", bus.busy);
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_both got busy=%b exp 0", bus.busy);
        end
        kick(4'd8, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.q !== 4'd1 || bus.cnt_en !== 1'b0) begin
            fails++;
            $display("FAIL run_both got busy=%b q=%0d en=%b exp 1 1 0",
                bus.busy, bus.q, bus.cnt_en);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL run_both_abort got busy=%b exp 0", bus.busy);
        end
        kick(4'd4, 1'b0);
        @(negedge clk);
        bus.limit = 4'd9;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.q !== 4'd4 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL latch_pre got q=%0d done=%b exp 4 0",
                bus.q, bus.done);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.q !== 4'd4) begin
            fails++;
            $display("FAIL latch_done got done=%b q=%0d exp 1 4",
                bus.done, bus.q);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.q !== 4'd4) begin
            fails++;
            $display("FAIL latch_idle got busy=%b q=%0d exp 0 4",
                bus.busy, bus.q);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_continuous();
        test_pause();
        test_corners();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
